// File: rtl/alu_writeback_pkg.sv
// Shared CPU definitions: opcode constants, PSR bit layout and the decode
// helpers that classify an opcode by its register and flag side effects.
package alu_writeback_pkg;

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_NOT  = 8'h04;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_ADDU = 8'h06;
   localparam logic [7:0] OP_ADDC = 8'h07;
   localparam logic [7:0] OP_RSH  = 8'h08;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_CMP  = 8'h0B;
   localparam logic [7:0] OP_ALSH = 8'h0C;
   localparam logic [7:0] OP_ARSH = 8'h0F;
   localparam logic [7:0] OP_LSH  = 8'h84;

   localparam int PSR_C = 0;
   localparam int PSR_L = 2;
   localparam int PSR_F = 5;
   localparam int PSR_Z = 6;
   localparam int PSR_N = 7;

   // Bits 1, 3 and 4 are unimplemented and must always read as zero.
   localparam logic [7:0] PSR_VALID_MASK = 8'hE5;

   typedef enum logic [1:0] {
      PSR_CLS_NONE,
      PSR_CLS_ARITH,
      PSR_CLS_CMP
   } psr_class_e;

   function automatic logic is_reg_write(input logic [7:0] op);
      logic wr;
      wr = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC,
         OP_RSH, OP_SUB, OP_ALSH, OP_ARSH, OP_LSH: wr = 1'b1;
         default: wr = 1'b0;
      endcase
      return wr;
   endfunction

   function automatic psr_class_e psr_class(input logic [7:0] op);
      psr_class_e cls;
      cls = PSR_CLS_NONE;
      case (op)
         OP_ADD, OP_SUB: cls = PSR_CLS_ARITH;
         OP_CMP:         cls = PSR_CLS_CMP;
         default:        cls = PSR_CLS_NONE;
      endcase
      return cls;
   endfunction

   function automatic logic [7:0] psr_mask(input psr_class_e cls);
      logic [7:0] m;
      m = '0;
      case (cls)
         PSR_CLS_ARITH: begin
            m[PSR_C] = 1'b1;
            m[PSR_F] = 1'b1;
         end
         PSR_CLS_CMP: begin
            m[PSR_L] = 1'b1;
            m[PSR_Z] = 1'b1;
            m[PSR_N] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result input handshake and register-file write-back port, bundled.
interface alu_writeback_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] rout;
   logic [7:0]        flags_alu;
   logic [7:0]        opcode;
   logic [REG_AW-1:0] dest;
   logic              wb_en;
   logic              wb_ready;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [7:0]        psr;
   logic [15:0]       retired;

   modport slave (
      input  in_valid, rout, flags_alu, opcode, dest, wb_ready,
      output in_ready, wb_en, wb_addr, wb_data, psr, retired
   );

   modport master (
      output in_valid, rout, flags_alu, opcode, dest, wb_ready,
      input  in_ready, wb_en, wb_addr, wb_data, psr, retired
   );
endinterface

// File: rtl/alu_writeback_psr_reg.sv
// Masked 8-bit flag register: only bits selected by mask load from d on we.
module psr_reg
   import alu_writeback_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [7:0] mask,
   input  logic [7:0] d,
   output logic [7:0] q
);

   logic [7:0] eff_mask;

   assign eff_mask = mask & PSR_VALID_MASK;

   // NOTE: reset sits in the sensitivity list so the flags clear without a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 8'h00;
      end else if (we) begin
         q <= (q & ~eff_mask) | (d & eff_mask);
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: one-entry output register toward the register file,
// PSR update on accept, and a retired-instruction counter.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic            clk,
   input  logic            reset,
   alu_writeback_if.slave  bus
);

   logic              in_ready;
   logic              accept;
   logic              wb_en_q;
   logic [REG_AW-1:0] wb_addr_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [15:0]       retired_q;
   logic [7:0]        psr_wr_mask;

   // A new result may enter whenever the slot is empty or draining this cycle.
   assign in_ready    = !wb_en_q || bus.wb_ready;
   assign accept      = bus.in_valid && in_ready;
   assign psr_wr_mask = psr_mask(psr_class(bus.opcode));

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         retired_q <= '0;
      end else if (accept) begin
         retired_q <= retired_q + 16'd1;
         wb_en_q   <= is_reg_write(bus.opcode);
         if (is_reg_write(bus.opcode)) begin
            wb_addr_q <= bus.dest;
            wb_data_q <= bus.rout;
         end
      end else if (wb_en_q && bus.wb_ready) begin
         wb_en_q <= 1'b0;
      end
   end

   psr_reg u_psr_reg (
      .clk   (clk),
      .reset (reset),
      .we    (accept),
      .mask  (psr_wr_mask),
      .d     (bus.flags_alu),
      .q     (bus.psr)
   );

   assign bus.in_ready = in_ready;
   assign bus.wb_en    = wb_en_q;
   assign bus.wb_addr  = wb_addr_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, stall/reset
// sequences, counter wrap, and randomized traffic against a behavioural model.
module tb_alu_writeback;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   alu_writeback_if #(.DATA_W(16), .REG_AW(4)) bus ();

   alu_writeback #(.DATA_W(16), .REG_AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid;
      logic [7:0]  op;
      logic [15:0] rout;
      logic [7:0]  flags;
      logic [3:0]  dest;
      logic        wb_ready;
      logic        exp_en;
      logic [3:0]  exp_addr;
      logic [15:0] exp_data;
      logic [7:0]  exp_psr;
      logic [15:0] exp_ret;
   } vec_t;

   vec_t vecs [9];

   // Behavioural model state
   logic        m_en;
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   logic [7:0]  m_psr;
   int          m_ret;

   logic [7:0] wr_ops [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h07, 8'h08, 8'h09, 8'h0C, 8'h0F, 8'h84};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] r,
                        input logic [7:0] f, input logic [3:0] d, input logic wr);
      bus.in_valid  = v;
      bus.opcode    = op;
      bus.rout      = r;
      bus.flags_alu = f;
      bus.dest      = d;
      bus.wb_ready  = wr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic en, input logic [3:0] a,
                              input logic [15:0] dat, input logic [7:0] p, input logic [15:0] ret);
      check({tag, ".wb_en"},   {31'd0, bus.wb_en}, {31'd0, en});
      check({tag, ".wb_addr"}, {28'd0, bus.wb_addr}, {28'd0, a});
      check({tag, ".wb_data"}, {16'd0, bus.wb_data}, {16'd0, dat});
      check({tag, ".psr"},     {24'd0, bus.psr}, {24'd0, p});
      check({tag, ".retired"}, {16'd0, bus.retired}, {16'd0, ret});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 8'h00, 16'h0000, 8'h00, 4'h0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic model_writes(input logic [7:0] op);
      return op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                        8'h07, 8'h08, 8'h09, 8'h0C, 8'h0F, 8'h84};
   endfunction

   task automatic model_reset();
      m_en = 1'b0; m_addr = '0; m_data = '0; m_psr = 8'h00; m_ret = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] op, input logic [15:0] r,
                             input logic [7:0] f, input logic [3:0] d, input logic wr);
      bit takes;
      takes = v && (!m_en || wr);
      if (takes) begin
         m_ret = (m_ret + 1) % 65536;
         if (op == 8'h05 || op == 8'h09) begin
            m_psr[0] = f[0];
            m_psr[5] = f[5];
         end else if (op == 8'h0B) begin
            m_psr[2] = f[2];
            m_psr[6] = f[6];
            m_psr[7] = f[7];
         end
         if (model_writes(op)) begin
            m_en = 1'b1; m_addr = d; m_data = r;
         end else begin
            m_en = 1'b0;
         end
      end else if (m_en && wr) begin
         m_en = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(1'b0, 8'h00, 16'h0000, 8'h00, 4'h0, 1'b1);

      vecs[0] = '{1'b1, 8'h05, 16'h0000, 8'h01, 4'd3,  1'b1, 1'b1, 4'd3,  16'h0000, 8'h01, 16'd1};
      vecs[1] = '{1'b1, 8'h01, 16'h00F0, 8'hFF, 4'd2,  1'b1, 1'b1, 4'd2,  16'h00F0, 8'h01, 16'd2};
      vecs[2] = '{1'b1, 8'h05, 16'h1234, 8'h21, 4'd5,  1'b1, 1'b1, 4'd5,  16'h1234, 8'h21, 16'd3};
      vecs[3] = '{1'b1, 8'h0B, 16'h0000, 8'h40, 4'd7,  1'b1, 1'b0, 4'd5,  16'h1234, 8'h61, 16'd4};
      vecs[4] = '{1'b1, 8'h09, 16'hABCD, 8'h00, 4'd9,  1'b1, 1'b1, 4'd9,  16'hABCD, 8'h40, 16'd5};
      vecs[5] = '{1'b1, 8'h10, 16'hDEAD, 8'hFF, 4'd1,  1'b1, 1'b0, 4'd9,  16'hABCD, 8'h40, 16'd6};
      vecs[6] = '{1'b1, 8'h84, 16'h5555, 8'hFF, 4'd15, 1'b1, 1'b1, 4'd15, 16'h5555, 8'h40, 16'd7};
      vecs[7] = '{1'b1, 8'h0B, 16'h0000, 8'hFF, 4'd0,  1'b1, 1'b0, 4'd15, 16'h5555, 8'hC4, 16'd8};
      vecs[8] = '{1'b0, 8'h05, 16'h7777, 8'h21, 4'd4,  1'b1, 1'b0, 4'd15, 16'h5555, 8'hC4, 16'd8};

      #2;
      check_state("reset", 1'b0, 4'd0, 16'h0000, 8'h00, 16'd0);

      @(negedge clk);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].in_valid, vecs[i].op, vecs[i].rout, vecs[i].flags,
               vecs[i].dest, vecs[i].wb_ready);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr,
                     vecs[i].exp_data, vecs[i].exp_psr, vecs[i].exp_ret);
         @(negedge clk);
      end

      // Back-pressure: slot fills, then a second result waits three cycles
      drive(1'b1, 8'h06, 16'h0606, 8'h00, 4'd4, 1'b0);
      #1 check("stall.in_ready0", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check_state("stall.load", 1'b1, 4'd4, 16'h0606, 8'hC4, 16'd9);
      @(negedge clk);
      drive(1'b1, 8'h05, 16'h0707, 8'h21, 4'd6, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1 check($sformatf("stall.in_ready_c%0d", c), {31'd0, bus.in_ready}, 32'd0);
         tick();
         check_state($sformatf("stall.hold%0d", c), 1'b1, 4'd4, 16'h0606, 8'hC4, 16'd9);
         @(negedge clk);
      end
      bus.wb_ready = 1'b1;
      #1 check("stall.release_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check_state("stall.release", 1'b1, 4'd6, 16'h0707, 8'hE5, 16'd10);
      @(negedge clk);
      drive(1'b0, 8'h00, 16'h0000, 8'h00, 4'd0, 1'b1);
      tick();
      check("drain.wb_en", {31'd0, bus.wb_en}, 32'd0);

      // Reset asserted in the middle of a stall
      do_reset();
      drive(1'b1, 8'h05, 16'h1111, 8'h21, 4'd1, 1'b0);
      tick();
      check_state("prerst", 1'b1, 4'd1, 16'h1111, 8'h21, 16'd1);
      @(negedge clk);
      drive(1'b0, 8'h00, 16'h0000, 8'h00, 4'd0, 1'b0);
      #2 reset = 1'b1;
      #1 check_state("midrst", 1'b0, 4'd0, 16'h0000, 8'h00, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 8'h02, 16'h2222, 8'h00, 4'd2, 1'b1);
      tick();
      check_state("postrst", 1'b1, 4'd2, 16'h2222, 8'h00, 16'd1);

      // Retired counter wrap
      do_reset();
      drive(1'b1, 8'h10, 16'h0000, 8'h00, 4'd0, 1'b1);
      repeat (65535) @(posedge clk);
      #1 check("wrap.ffff", {16'd0, bus.retired}, 32'h0000FFFF);
      tick();
      check("wrap.zero", {16'd0, bus.retired}, 32'h00000000);

      // Randomized traffic against the behavioural model
      do_reset();
      model_reset();
      for (int n = 0; n < 500; n++) begin
         logic        v, wr;
         logic [7:0]  op, f;
         logic [15:0] r;
         logic [3:0]  d;
         int          sel;
         sel = $urandom_range(0, 15);
         if (sel < 12)      op = wr_ops[sel];
         else if (sel < 14) op = 8'h0B;
         else               op = 8'($urandom_range(0, 255));
         v  = 1'($urandom_range(0, 3) != 0);
         wr = 1'($urandom_range(0, 2) != 0);
         f  = 8'($urandom_range(0, 255));
         r  = 16'($urandom_range(0, 65535));
         d  = 4'($urandom_range(0, 15));
         drive(v, op, r, f, d, wr);
         #1 check($sformatf("rnd%0d.in_ready", n), {31'd0, bus.in_ready},
                  {31'd0, (!m_en || wr)});
         model_step(v, op, r, f, d, wr);
         tick();
         check_state($sformatf("rnd%0d", n), m_en, m_addr, m_data, m_psr, 16'(m_ret));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
